edc_secded_pipe: RTL and testbench
==================================

Name: edc_secded_pipe

Overview:
Parametrised, pipelined SEC-DED encoder/decoder, successor to the fixed 32-bit combinational ECC generator. Encode mode returns check bits for write data. Decode mode returns corrected data, syndrome and error flags. Sits between the cache/memory controller and ECC-protected RAM, with valid/ready flow control, saturating error counters and first-fatal-error tag capture for the system registers.

Parameters:
DATA_WIDTH, 32, data word width; legal values 32 or 64.
ECC_WIDTH, 7, check bits; must be 7 when DATA_WIDTH=32 and 8 when DATA_WIDTH=64. Any other combination is an elaboration error.
TAG_WIDTH, 30, sideband tag (word address) carried with each transaction.
COUNT_WIDTH, 16, width of the saturating error counters.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  input transaction valid
o_ready  out  1  input accepted when i_valid && o_ready
i_write_enabled  in  1  1 = encode, 0 = decode
i_data  in  DATA_WIDTH  data word
i_ecc  in  ECC_WIDTH  stored check bits (decode only)
i_tag  in  TAG_WIDTH  transaction tag
o_valid  out  1  output valid
i_ready  in  1  output consumed when o_valid && i_ready
o_data  out  DATA_WIDTH  encode: i_data unchanged; decode: corrected data
o_ecc_syndrome  out  ECC_WIDTH  encode: generated check bits; decode: syndrome
o_single_err  out  1  correctable error (decode only)
o_double_err  out  1  uncorrectable error (decode only)
o_tag  out  TAG_WIDTH  tag of the output transaction
i_count_clr  in  1  synchronous clear of counters and capture
o_sec_count  out  COUNT_WIDTH  corrected-error count
o_ded_count  out  COUNT_WIDTH  uncorrectable-error count
o_fatal_tag  out  TAG_WIDTH  tag of the first uncorrectable error since clear
o_fatal_valid  out  1  o_fatal_tag is valid

Behaviour:
- Matrix (Hsiao):
  - Column for data bit i is the i-th ECC_WIDTH-bit value, in ascending numeric order, with odd weight >= 3. Width 7 gives 7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, ...
  - Column for check bit j is one-hot (1<<j).
  - Generated ecc = XOR of the columns of all set data bits.
  - Columns are built by a constant function at elaboration; no hand-coded tables.
- Pipeline: two register stages, latency 2 cycles from acceptance to o_valid with no stall.
  - S1 registers the inputs.
  - S2 registers the results.
  - Global stall when o_valid && !i_ready. o_ready = !(o_valid && !i_ready).
  - Stalled stages hold every bit. No bubbles are inserted; throughput is 1 per cycle.
- Decode classification, with syndrome s = generated ^ i_ecc:
  - s == 0: no error.
  - s equals data column k: flip data bit k, single_err=1.
  - s one-hot: check-bit error, data unchanged, single_err=1.
  - s even weight and nonzero: double_err=1, data passed uncorrected.
  - s odd weight but not a column: double_err=1, data passed uncorrected.
  - single_err and double_err are never both 1.
- Encode: o_ecc_syndrome = generated ecc; error flags are 0.
- Counters:
  - Increment on the output handshake (o_valid && i_ready) of a decode with the matching flag.
  - Saturate at all-ones; no wrap.
  - i_count_clr has priority over a simultaneous increment (result 0) and also clears o_fatal_valid.
- Fatal capture: on the first handshaked double_err while o_fatal_valid=0, load o_fatal_tag and set o_fatal_valid. Later errors do not overwrite it. Clear-and-capture in the same cycle: clear wins.
- Reset (async assert, sync deassert handled at top level):
  - o_valid=0, all data outputs 0, counters 0, o_fatal_valid=0, o_fatal_tag=0.
  - o_ready=1 the cycle after reset is released.
  - Reset mid-stream discards in-flight transactions.

Decomposition:
- Package edc_pkg holds:
  - column-generation function (width, index -> column)
  - popcount/parity helper functions
  - legal DATA_WIDTH/ECC_WIDTH pairing check
  - syndrome-class localparams: NONE, DATA, CHECK, DOUBLE
- Sub-module edc_syndrome_decode: combinational syndrome -> {flip mask, class}. Instantiated in the S1->S2 path and reusable by the scrubber.

Test Plan:
- Encode, DATA_WIDTH=32: i_data=32'h1 -> o_ecc_syndrome=7'h07 after 2 cycles; 32'h2 -> 7'h0B; 32'h0 -> 7'h00. Flags 0.
- Decode 32'h0 with i_ecc=7'h07 -> syndrome 7'h07, o_data=32'h1 becomes 32'h0 corrected? Concretely: i_data=32'h1, i_ecc=7'h00 -> syndrome 7'h07, o_data=32'h0, single_err=1, o_sec_count=1.
- Decode i_data=32'h3, i_ecc=7'h00 (bits 0 and 1 set) -> syndrome 7'h0C (even weight), double_err=1, o_data=32'h3, o_ded_count=1, o_fatal_tag=i_tag, o_fatal_valid=1.
- Backpressure: stream 4 back-to-back decodes with i_ready low for 3 cycles mid-stream -> all 4 delivered in order, none lost or duplicated; o_ready low while stalled.
- Counter saturation with COUNT_WIDTH=2: 5 single errors -> o_sec_count=2'b11. Assert i_count_clr on the same cycle as a 6th error handshake -> count 0.
- Assert reset with 2 transactions in flight -> o_valid=0 immediately, counters 0, no stale output after release.

Source files
------------

// File: rtl/edc_pkg.sv
// Shared SEC-DED helpers: Hsiao column generation, popcount/parity and
// the syndrome classification codes used by the pipeline and the scrubber.
package edc_pkg;

  localparam logic [1:0] SYN_NONE   = 2'd0;
  localparam logic [1:0] SYN_DATA   = 2'd1;
  localparam logic [1:0] SYN_CHECK  = 2'd2;
  localparam logic [1:0] SYN_DOUBLE = 2'd3;

  function automatic int unsigned popcount(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  function automatic logic parity(input logic [7:0] v);
    return ^v;
  endfunction

  // idx-th value of width ew, ascending, with odd weight >= 3.
  function automatic logic [7:0] hsiao_col(input int ew, input int idx);
    logic [7:0] col;
    int         cnt;
    col = '0;
    cnt = 0;
    for (int v = 3; v < (1 << ew); v++) begin
      if (parity(8'(v)) && popcount(8'(v)) >= 3) begin
        if (cnt == idx) col = 8'(v);
        cnt++;
      end
    end
    return col;
  endfunction

  function automatic logic legal_cfg(input int dw, input int ew);
    return ((dw == 32) && (ew == 7)) || ((dw == 64) && (ew == 8));
  endfunction

endpackage

// File: rtl/edc_syndrome_decode.sv
// Combinational syndrome decoder: maps a syndrome to a data flip mask and
// an error class. Shared by the decode pipeline and the memory scrubber.
module edc_syndrome_decode
  import edc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ECC_WIDTH  = 7
) (
  input  logic [ECC_WIDTH-1:0]  i_syndrome,
  output logic [DATA_WIDTH-1:0] o_flip_mask,
  output logic [1:0]            o_class
);

  logic [ECC_WIDTH-1:0] w_col [DATA_WIDTH];

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_col
    localparam logic [7:0] COL = hsiao_col(ECC_WIDTH, g);
    assign w_col[g] = COL[ECC_WIDTH-1:0];
  end

  always_comb begin
    o_flip_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) o_flip_mask[i] = (i_syndrome == w_col[i]);
    // Odd-weight syndromes that match no column are uncorrectable too.
    if (i_syndrome == '0)                        o_class = SYN_NONE;
    else if (|o_flip_mask)                       o_class = SYN_DATA;
    else if (popcount(8'(i_syndrome)) == 32'd1)  o_class = SYN_CHECK;
    else                                         o_class = SYN_DOUBLE;
  end

endmodule

// File: rtl/edc_secded_pipe.sv
// Two-stage pipelined Hsiao SEC-DED encoder/decoder with valid/ready flow
// control, saturating error counters and first-fatal-error tag capture.
module edc_secded_pipe
  import edc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ECC_WIDTH   = 7,
  parameter int TAG_WIDTH   = 30,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_write_enabled,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [ECC_WIDTH-1:0]   i_ecc,
  input  logic [TAG_WIDTH-1:0]   i_tag,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [ECC_WIDTH-1:0]   o_ecc_syndrome,
  output logic                   o_single_err,
  output logic                   o_double_err,
  output logic [TAG_WIDTH-1:0]   o_tag,
  input  logic                   i_count_clr,
  output logic [COUNT_WIDTH-1:0] o_sec_count,
  output logic [COUNT_WIDTH-1:0] o_ded_count,
  output logic [TAG_WIDTH-1:0]   o_fatal_tag,
  output logic                   o_fatal_valid
);

  if (!legal_cfg(DATA_WIDTH, ECC_WIDTH)) begin : g_bad_cfg
    $error("edc_secded_pipe: illegal DATA_WIDTH/ECC_WIDTH pairing");
  end

  // Handshake: a beat moves on either side when valid && ready. The whole
  // pipe stalls as one while the output beat is held, so no bubbles appear.
  logic w_stall, w_hs;
  assign w_stall = o_valid && !i_ready;
  assign w_hs    = o_valid && i_ready;
  assign o_ready = !w_stall;

  logic                  r1_valid, r1_we;
  logic [DATA_WIDTH-1:0] r1_data;
  logic [ECC_WIDTH-1:0]  r1_ecc;
  logic [TAG_WIDTH-1:0]  r1_tag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_valid <= 1'b0;
      r1_we    <= 1'b0;
      r1_data  <= '0;
      r1_ecc   <= '0;
      r1_tag   <= '0;
    end else if (!w_stall) begin
      r1_valid <= i_valid;
      r1_we    <= i_write_enabled;
      r1_data  <= i_data;
      r1_ecc   <= i_ecc;
      r1_tag   <= i_tag;
    end
  end

  logic [ECC_WIDTH-1:0] w_col [DATA_WIDTH];
  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_col
    localparam logic [7:0] COL = hsiao_col(ECC_WIDTH, g);
    assign w_col[g] = COL[ECC_WIDTH-1:0];
  end

  logic [ECC_WIDTH-1:0]  w_gen, w_syn;
  logic [DATA_WIDTH-1:0] w_flip;
  logic [1:0]            w_class;

  always_comb begin
    w_gen = '0;
    for (int i = 0; i < DATA_WIDTH; i++) w_gen = w_gen ^ (w_col[i] & {ECC_WIDTH{r1_data[i]}});
  end

  assign w_syn = w_gen ^ r1_ecc;

  edc_syndrome_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .ECC_WIDTH  (ECC_WIDTH)
  ) u_syn_dec (
    .i_syndrome  (w_syn),
    .o_flip_mask (w_flip),
    .o_class     (w_class)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid        <= 1'b0;
      o_data         <= '0;
      o_ecc_syndrome <= '0;
      o_single_err   <= 1'b0;
      o_double_err   <= 1'b0;
      o_tag          <= '0;
    end else if (!w_stall) begin
      o_valid        <= r1_valid;
      o_data         <= r1_we ? r1_data : (r1_data ^ w_flip);
      o_ecc_syndrome <= r1_we ? w_gen : w_syn;
      o_single_err   <= !r1_we && ((w_class == SYN_DATA) || (w_class == SYN_CHECK));
      o_double_err   <= !r1_we && (w_class == SYN_DOUBLE);
      o_tag          <= r1_tag;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sec_count   <= '0;
      o_ded_count   <= '0;
      o_fatal_tag   <= '0;
      o_fatal_valid <= 1'b0;
    end else if (i_count_clr) begin
      o_sec_count   <= '0;
      o_ded_count   <= '0;
      o_fatal_tag   <= '0;
      o_fatal_valid <= 1'b0;
    end else if (w_hs) begin
      if (o_single_err && (o_sec_count != '1)) o_sec_count <= o_sec_count + 1'b1;
      if (o_double_err && (o_ded_count != '1)) o_ded_count <= o_ded_count + 1'b1;
      if (o_double_err && !o_fatal_valid) begin
        o_fatal_tag   <= o_tag;
        o_fatal_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_edc_secded_pipe.sv
// Self-checking bench for edc_secded_pipe (32-bit data, 2-bit counters).
module tb_edc_secded_pipe;

  localparam int DW = 32;
  localparam int EW = 7;
  localparam int TW = 30;
  localparam int CW = 2;

  logic          clk, rst_n;
  logic          i_valid, o_ready, i_we, i_ready, i_count_clr;
  logic [DW-1:0] i_data, o_data;
  logic [EW-1:0] i_ecc, o_syn;
  logic [TW-1:0] i_tag, o_tag, o_fatal_tag;
  logic          o_valid, o_single, o_double, o_fatal_valid;
  logic [CW-1:0] o_sec, o_ded;

  edc_secded_pipe #(
    .DATA_WIDTH (DW), .ECC_WIDTH (EW), .TAG_WIDTH (TW), .COUNT_WIDTH (CW)
  ) dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_valid (i_valid), .o_ready (o_ready), .i_write_enabled (i_we),
    .i_data (i_data), .i_ecc (i_ecc), .i_tag (i_tag),
    .o_valid (o_valid), .i_ready (i_ready),
    .o_data (o_data), .o_ecc_syndrome (o_syn),
    .o_single_err (o_single), .o_double_err (o_double), .o_tag (o_tag),
    .i_count_clr (i_count_clr), .o_sec_count (o_sec), .o_ded_count (o_ded),
    .o_fatal_tag (o_fatal_tag), .o_fatal_valid (o_fatal_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] syn;
    logic          single;
    logic          dbl;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [CW-1:0] m_sec, m_ded;
  logic          m_fv;
  logic [TW-1:0] m_ft;

  function automatic logic [EW-1:0] ref_col(input int k);
    int n;
    n = 0;
    for (int v = 0; v < (1 << EW); v++) begin
      if (($countones(v) % 2 == 1) && ($countones(v) >= 3)) begin
        if (n == k) return EW'(v);
        n++;
      end
    end
    return '0;
  endfunction

  function automatic logic [EW-1:0] ref_encode(input logic [DW-1:0] d);
    logic [EW-1:0] e;
    e = '0;
    for (int i = 0; i < DW; i++) if (d[i]) e = e ^ ref_col(i);
    return e;
  endfunction

  function automatic exp_t ref_txn(input logic we, input logic [DW-1:0] d,
                                   input logic [EW-1:0] e, input logic [TW-1:0] t);
    exp_t          r;
    logic [EW-1:0] g;
    logic          found;
    g        = ref_encode(d);
    r.data   = d;
    r.tag    = t;
    r.single = 1'b0;
    r.dbl    = 1'b0;
    if (we) begin
      r.syn = g;
    end else begin
      r.syn = g ^ e;
      found = 1'b0;
      if (r.syn != '0) begin
        for (int k = 0; k < DW; k++) begin
          if (ref_col(k) == r.syn) begin
            r.data[k] = ~r.data[k];
            found     = 1'b1;
          end
        end
        if (found || ($countones(r.syn) == 1)) r.single = 1'b1;
        else                                   r.dbl    = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    logic hs_single, hs_double;
    hs_single = 1'b0;
    hs_double = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_sec = '0; m_ded = '0; m_fv = 1'b0; m_ft = '0;
      check("rst_o_valid", o_valid, 0);
      check("rst_sec", o_sec, 0);
      check("rst_ded", o_ded, 0);
      check("rst_fatal_valid", o_fatal_valid, 0);
    end else begin
      check("o_ready", o_ready, !(o_valid && !i_ready));
      check("sec_count", o_sec, m_sec);
      check("ded_count", o_ded, m_ded);
      check("fatal_valid", o_fatal_valid, m_fv);
      if (m_fv) check("fatal_tag", o_fatal_tag, m_ft);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got tag %0h expected no output", o_tag);
        end else begin
          e = exp_q.pop_front();
          check("out_data", o_data, e.data);
          check("out_syndrome", o_syn, e.syn);
          check("out_single", o_single, e.single);
          check("out_double", o_double, e.dbl);
          check("out_tag", o_tag, e.tag);
          hs_single = e.single;
          hs_double = e.dbl;
          if (i_count_clr) ;
          else if (hs_double && !m_fv) begin
            m_fv = 1'b1;
            m_ft = e.tag;
          end
        end
      end
      if (i_valid && o_ready) exp_q.push_back(ref_txn(i_we, i_data, i_ecc, i_tag));
      if (i_count_clr) begin
        m_sec = '0; m_ded = '0; m_fv = 1'b0;
      end else begin
        if (hs_single && m_sec != '1) m_sec = m_sec + 1'b1;
        if (hs_double && m_ded != '1) m_ded = m_ded + 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [DW-1:0] d, input logic [EW-1:0] e,
                      input logic [TW-1:0] t);
    logic acc;
    i_valid = 1'b1; i_we = we; i_data = d; i_ecc = e; i_tag = t;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no acceptance expected acceptance of tag %0h", t);
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  function automatic logic [EW-1:0] single_err_ecc(input logic [DW-1:0] d);
    return ref_encode(d) ^ (EW'(1) << $urandom_range(0, EW - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    logic [38:0]   cw;
    exp_t          x;
    rst_n = 1'b0; i_valid = 1'b0; i_we = 1'b0; i_data = '0; i_ecc = '0; i_tag = '0;
    i_ready = 1'b1; i_count_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the model to hand-computed values.
    check("pin_col0", ref_col(0), 7'h07);
    check("pin_col1", ref_col(1), 7'h0B);
    check("pin_col4", ref_col(4), 7'h13);
    check("pin_enc0", ref_encode(32'h0), 7'h00);
    x = ref_txn(1'b0, 32'h1, 7'h00, '0);
    check("pin_sec_data", x.data, 32'h0);
    check("pin_sec_syn", x.syn, 7'h07);
    check("pin_sec_flag", {x.single, x.dbl}, 2'b10);
    x = ref_txn(1'b0, 32'h3, 7'h00, '0);
    check("pin_ded_syn", x.syn, 7'h0C);
    check("pin_ded_data", x.data, 32'h3);
    check("pin_ded_flag", {x.single, x.dbl}, 2'b01);

    // Latency of a single encode.
    @(posedge clk); #1;
    i_valid = 1'b1; i_we = 1'b1; i_data = 32'h1; i_ecc = '0; i_tag = 30'h5;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("lat_cycle1_valid", o_valid, 0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", o_valid, 1);
    check("lat_ecc", o_syn, 7'h07);
    check("lat_flags", {o_single, o_double}, 2'b00);

    // Directed encode/decode sequence.
    send(1'b1, 32'h2, 7'h00, 30'h1);
    send(1'b1, 32'h0, 7'h00, 30'h2);
    send(1'b0, 32'h1, 7'h00, 30'h11);
    send(1'b0, 32'h3, 7'h00, 30'h22);
    drain("dir_drained");
    check("dir_sec", o_sec, 1);
    check("dir_ded", o_ded, 1);
    check("dir_fatal_valid", o_fatal_valid, 1);
    check("dir_fatal_tag", o_fatal_tag, 30'h22);

    // Backpressure mid-stream.
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          d = $urandom;
          send(1'b0, d, single_err_ecc(d), TW'(30'h100 + i));
        end
        i_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain("bp_drained");

    // Saturation and clear priority.
    i_count_clr = 1'b1;
    @(posedge clk); #1;
    i_count_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      send(1'b0, d, single_err_ecc(d), TW'(30'h200 + i));
    end
    drain("sat_drained");
    check("sat_sec", o_sec, 2'b11);
    i_ready = 1'b0;
    d = $urandom;
    send(1'b0, d, single_err_ecc(d), 30'h206);
    i_valid = 1'b0;
    for (int i = 0; i < 10 && !o_valid; i++) begin
      @(posedge clk); #1;
    end
    check("sixth_out_valid", o_valid, 1);
    i_ready = 1'b1; i_count_clr = 1'b1;
    @(posedge clk); #1;
    i_count_clr = 1'b0;
    check("clr_wins_sec", o_sec, 0);

    // Reset with two transactions in flight.
    d = $urandom;
    send(1'b0, d, single_err_ecc(d), 30'h300);
    drain("pre_rst_drained");
    send(1'b0, 32'h1, 7'h00, 30'h301);
    send(1'b0, 32'h3, 7'h00, 30'h302);
    i_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_now_valid", o_valid, 0);
    check("rst_now_sec", o_sec, 0);
    check("rst_now_ded", o_ded, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      i_valid     = ($urandom_range(0, 3) != 0);
      i_we        = ($urandom_range(0, 3) == 0);
      i_ready     = ($urandom_range(0, 3) != 0);
      i_count_clr = ($urandom_range(0, 29) == 0);
      i_tag       = TW'($urandom);
      d           = $urandom;
      cw          = {ref_encode(d), d};
      for (int f = $urandom_range(0, 3); f > 0; f--) cw[$urandom_range(0, 38)] ^= 1'b1;
      i_data      = cw[31:0];
      e           = cw[38:32];
      i_ecc       = i_we ? EW'($urandom) : e;
      @(posedge clk); #1;
    end
    i_count_clr = 1'b0;
    drain("rand_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
